// File: rtl/javk_uart_tx.sv
// javk_uart_tx: CPU-mapped UART transmitter (DATA at BASE, STATUS at BASE+1) with a FIFO_DEPTH byte queue; frame starts one clk after a byte lands.
// Writes to a full queue are dropped and latch sticky overflow; define JAVK_UART_TX_PARITY_EN for an even-parity bit (11-bit frame).

// javk_uart_tx_fifo: small synchronous FIFO, head visible combinationally, push/pop take effect on the same edge.
// A push to a full FIFO is accepted only when a pop happens on that edge; otherwise it is flagged on o_drop.
module javk_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push_vld,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop_vld,
  output logic [W-1:0]           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_count    = r_count;
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rptr];
  assign w_pop      = i_pop_vld && !o_empty;
  assign w_push     = i_push_vld && (!o_full || w_pop);
  assign o_drop     = i_push_vld && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end
endmodule

module javk_uart_tx #(
  parameter logic [15:0] BASE       = 16'hFF00,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic        tx
);
  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_START  = 3'd1;
  localparam logic [2:0]  S_DATA   = 3'd2;
  localparam logic [2:0]  S_PARITY = 3'd3;
  localparam logic [2:0]  S_STOP   = 3'd4;
  localparam logic [15:0] STAT_ADDR = BASE + 16'd1;
  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_par;
  logic        r_ovf;

  logic        w_wr;
  logic        w_stat_rd;
  logic        w_rd_en;
  logic [7:0]  w_rd_dat;
  logic [7:0]  w_status;
  logic        w_pop;
  logic [7:0]  w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;
  logic        w_busy;

  assign w_wr      = !rw && (addrbus == BASE);
  assign w_stat_rd = rw && (addrbus == STAT_ADDR);
  assign w_rd_en   = rw && ((addrbus == BASE) || (addrbus == STAT_ADDR));
  assign w_busy    = (r_state != S_IDLE);
  assign w_status  = {4'(w_count), r_ovf, w_empty, w_full, w_busy};
  assign w_rd_dat  = (addrbus == STAT_ADDR) ? w_status : 8'h00;
  assign databus   = w_rd_en ? w_rd_dat : 8'hzz;

  javk_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_wr),
    .i_push_dat (databus),
    .i_pop_vld  (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop)
  );

  // Pop from IDLE, or at the last cycle of STOP so the next start bit follows with no gap.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (r_state == S_IDLE) w_pop = 1'b1;
      else if ((r_state == S_STOP) && (r_cnt == 16'd0)) w_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_stat_rd) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_shift <= 8'h00;
      r_bit   <= 3'd0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_START;
            r_cnt   <= DIV_M1;
            r_shift <= w_head;
            r_par   <= ^w_head;
          end
        end
        S_START: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_DATA;
            r_cnt   <= DIV_M1;
            r_bit   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= DIV_M1;
            if (r_bit == 3'd7) begin
`ifdef JAVK_UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_STOP;
            r_cnt   <= DIV_M1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (r_cnt == 16'd0) begin
            if (w_pop) begin
              r_state <= S_START;
              r_cnt   <= DIV_M1;
              r_shift <= w_head;
              r_par   <= ^w_head;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = r_shift[0];
      S_PARITY: tx = r_par;
      default:  tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_javk_uart_tx.sv
// Bench for javk_uart_tx: CPU bus driver, serial-line decoder and a byte scoreboard.
module tb_javk_uart_tx;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] STAT  = 16'hFF01;
  localparam int          DIV   = 16;
  localparam int          DEPTH = 4;
`ifdef JAVK_UART_TX_PARITY_EN
  localparam int          FB    = 11;
`else
  localparam int          FB    = 10;
`endif
  localparam int          FRAME = FB * DIV;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] addrbus = 16'h0000;
  logic        rw      = 1'b1;
  logic [7:0]  tb_dat  = 8'h00;
  logic        tb_drv  = 1'b0;
  wire  [7:0]  databus;
  wire         tx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int wr_cyc      = 0;
  int exp_start   = -1;
  logic [7:0] exp_q[$];
  int         starts[$];

  assign databus = tb_drv ? tb_dat : 8'hzz;

  javk_uart_tx #(
    .BASE       (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addrbus (addrbus),
    .rw      (rw),
    .databus (databus),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    addrbus = 16'h0000;
    rw      = 1'b1;
    tb_drv  = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    addrbus = a;
    rw      = 1'b0;
    tb_dat  = d;
    tb_drv  = 1'b1;
    wr_cyc  = cyc;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    addrbus = a;
    rw      = 1'b1;
    tb_drv  = 1'b0;
    #1 d = databus;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Serial decoder: samples each bit at its centre, pops the scoreboard at the start bit.
  initial begin : monitor
    logic [7:0] exp_b;
    logic [7:0] got;
    int         bi;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        starts.push_back(cyc);
        if (exp_start >= 0) begin
          check_val("start_latency", cyc, exp_start);
          exp_start = -1;
        end
        check_val("frame_expected", int'(exp_q.size() > 0), 1);
        exp_b   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        got     = 8'h00;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k != 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (k % DIV == DIV / 2) begin
            bi = k / DIV;
            if (bi == 0) check_val("start_bit", int'(tx), 0);
            else if (bi <= 8) got[bi-1] = tx;
            else if (bi == FB - 1) check_val("stop_bit", int'(tx), 1);
`ifdef JAVK_UART_TX_PARITY_EN
            else check_val("parity_bit", int'(tx), int'(^exp_b));
`endif
          end
        end
        if (!aborted) check_val("frame_byte", int'(got), int'(exp_b));
      end
    end
  end

  initial begin : stim
    logic [7:0] d;
    logic [7:0] burst [6];
    int n;
    int burst_n;
    int n0;
    int toggles;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    bus_idle();
    #1 check_val("rst_tx", int'(tx), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_rd(STAT, d);
    check_val("stat_after_rst", int'(d), 32'h04);
    bus_idle();
    #1 check_val("bus_hiz", int'((databus === 8'hzz) || (databus === 8'h00)), 1);
    check_val("tx_idle", int'(tx), 1);
    @(negedge clk);

    // Single frame: latency, bit order and busy duration.
    exp_q.push_back(8'hA5);
    exp_start = cyc + 2;
    bus_wr(BASE, 8'hA5);
    n = wr_cyc;
    bus_idle();
    wait_cyc(n + 1 + FRAME);
    bus_rd(STAT, d);
    check_val("busy_last_cycle", int'(d), 32'h05);
    bus_rd(STAT, d);
    check_val("busy_cleared", int'(d), 32'h04);
    bus_idle();
    repeat (4) @(negedge clk);

    // Burst of six: first is popped at once, four queue, sixth overflows.
    starts.delete();
    burst_n = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(burst[i]);
      bus_wr(BASE, burst[i]);
    end
    bus_rd(STAT, d);
    check_val("stat_overflow", int'(d), 32'h4B);
    bus_rd(STAT, d);
    check_val("overflow_cleared", int'(d), 32'h43);
    bus_idle();

    // Push into the full FIFO on the edge the STOP bit ends and pops.
    wait_cyc(burst_n + 1 + FRAME);
    exp_q.push_back(8'h77);
    bus_wr(BASE, 8'h77);
    bus_rd(STAT, d);
    check_val("push_on_pop", int'(d), 32'h43);
    bus_idle();
    for (int i = 0; i < 8 * FRAME && exp_q.size() > 0; i++) @(negedge clk);
    repeat (FRAME + 4) @(negedge clk);
    check_val("drain", exp_q.size(), 0);
    check_val("frame_count", starts.size(), 6);
    for (int i = 1; i < starts.size(); i++)
      check_val("b2b_gap", starts[i] - starts[i-1], FRAME);
    bus_rd(STAT, d);
    check_val("stat_idle", int'(d), 32'h04);

    // STATUS writes are ignored, DATA reads return zero.
    n0 = starts.size();
    bus_wr(STAT, 8'hFF);
    bus_rd(STAT, d);
    check_val("stat_wr_ignored", int'(d), 32'h04);
    bus_rd(BASE, d);
    check_val("data_rd_zero", int'(d), 32'h00);
    bus_idle();
    repeat (3) @(negedge clk);
    check_val("no_frame_from_stat_wr", starts.size(), n0);

    // Reset in the middle of data bit 4 (a zero bit of 8'h0F).
    exp_q.push_back(8'h0F);
    bus_wr(BASE, 8'h0F);
    n = wr_cyc;
    bus_idle();
    wait_cyc(n + 2 + 5 * DIV + DIV / 2);
    check_val("pre_rst_tx", int'(tx), 0);
    #2 rst = 1'b1;
    #1 check_val("rst_tx_async", int'(tx), 1);
    exp_q.delete();
    n0 = starts.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_rd(STAT, d);
    check_val("stat_post_abort", int'(d), 32'h04);
    bus_idle();
    toggles = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx != 1'b1) toggles++;
    end
    check_val("tx_quiet", toggles, 0);
    check_val("no_frame_after_rst", starts.size(), n0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
